hex_scan_driver: RTL
====================

HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

Interface
REQ-001 Parameter DIGITS, default 8, is the number of 4-bit hex digits scanned, legal range 1..16.
REQ-002 Parameter REFRESH_DIV, default 50000, is the number of clk cycles each digit stays lit, legal range >= 2.
REQ-003 Parameter ACTIVE_LOW, default 1, sets output polarity: 1 drives lit segments and anodes low, 0 drives them high.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 wr_en  input  1  write strobe; wr_data is captured in the cycle it is high.
REQ-007 wr_data  input  4*DIGITS  value to display; nibble i drives digit i, and nibble 0 is the least significant.
REQ-008 seg  output  7  registered segment pattern; bit0=a through bit6=g.
REQ-009 an  output  DIGITS  registered one-hot digit enable.
REQ-010 frame_done  output  1  one-cycle pulse at the end of each full scan frame.
REQ-011 update_pending  output  1  high while a captured value waits for the next frame boundary.

Function
REQ-012 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick is asserted in the cycle where the count equals REFRESH_DIV-1.
REQ-013 On tick, digit index idx SHALL advance by 1 and wrap from DIGITS-1 to 0.
REQ-014 A frame boundary is tick with idx==DIGITS-1; frame_done SHALL be registered and high for exactly the one cycle after the boundary.
REQ-015 wr_en SHALL load wr_data into a pending register and set update_pending in the following cycle.
REQ-016 At a frame boundary with update_pending set, the pending register SHALL copy into the display register and update_pending SHALL clear.
REQ-017 wr_en coincident with a frame boundary SHALL load wr_data directly into the display register, leaving update_pending clear.
REQ-018 A wr_en arriving while update_pending is set SHALL overwrite the pending value: last write wins, and no values are queued.
REQ-019 The display register SHALL never change mid-frame, so no tearing occurs.
REQ-020 seg and an SHALL reflect idx and the display register with exactly one clk of latency.
REQ-021 seg SHALL use standard hex glyphs 0-F (b and d lowercase), for example 0 = a..f lit and 8 = all lit.
REQ-022 an SHALL enable only bit idx; every other bit is off at the polarity set by ACTIVE_LOW.
REQ-023 Arithmetic widths: the prescaler SHALL be $clog2(REFRESH_DIV) bits and idx SHALL be max(1,$clog2(DIGITS)) bits, with no overflow beyond the wrap points.

Reset
REQ-024 While rst is high, prescaler, idx, display register, pending register, update_pending and frame_done SHALL be 0, and seg and an SHALL be all off.
REQ-025 In the first cycle after rst deasserts, digit 0 SHALL be lit showing "0".
REQ-026 rst mid-frame or mid-pending SHALL discard the pending value and restart at digit 0 with the prescaler at 0.

Configuration
REQ-027 With macro LEADING_ZERO_BLANK_EN defined, digit i>0 SHALL be blanked (all segments off, anode still enabled) when nibble i and all higher nibbles are zero, and digit 0 is never blanked.
REQ-028 Without LEADING_ZERO_BLANK_EN, every digit SHALL show its glyph including leading zeros, and no blanking logic is synthesised.

Verification (DIGITS=8, REFRESH_DIV=4, ACTIVE_LOW=1)
REQ-029 Reset release -> an=8'hFE and seg=7'b1000000; an rotates to 8'hFD after 4 cycles, and frame_done pulses every 32 cycles.
REQ-030 Write 32'h0000_3039 mid-frame -> update_pending=1 until the boundary; digits 3..0 then show 3,0,3,9 in the next frame, and the current frame still shows 0.
REQ-031 Writes 32'h1111_1111 then 32'h2222_2222 in one frame -> the next frame shows all 2s, and 1s never appear.
REQ-032 wr_en in the boundary cycle with 32'hDEAD_BEEF -> the next frame shows DEADBEEF with update_pending staying 0, and seg for D = 7'b0100001.
REQ-033 rst pulse while update_pending=1 -> pending cleared, display 0, and scan restarts at an=8'hFE.
REQ-034 LEADING_ZERO_BLANK_EN with value 32'h0000_00A0 -> digits 7..2 have seg=7'h7F, digit 1 = A, digit 0 = 0.

Source files
------------

// File: rtl/hex_scan_driver.sv
// ---------------------------------------------------------------------------
// hex_scan_driver
//
// Time-multiplexed driver for a bank of 7-segment hex digits. A prescaler
// holds each digit lit for REFRESH_DIV clocks, and then the scan moves to the
// next digit. Host writes go to a pending register. They move into the
// display register only at a frame boundary, so a frame never shows a mix of
// old and new digits.
//
// Parameters:
//   DIGITS      number of 4-bit hex digits scanned (1..16)
//   REFRESH_DIV clk cycles each digit stays lit (>= 2)
//   ACTIVE_LOW  1: lit segments and anodes are driven low; 0: driven high
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   wr_en          write strobe; wr_data is captured in the same cycle
//   wr_data        value to display, nibble i -> digit i (nibble 0 is the LSB)
//   seg            registered segment pattern, bit0 = a ... bit6 = g
//   an             registered one-hot digit enable
//   frame_done     one-cycle pulse after each full scan frame
//   update_pending a captured value is waiting for the next frame boundary
//
// Optional feature (compile-time macro):
//   LEADING_ZERO_BLANK_EN  blanks leading-zero digits above digit 0
// ---------------------------------------------------------------------------
module hex_scan_driver #(
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [4*DIGITS-1:0]   wr_data,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done,
    output logic                  update_pending
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0]     PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF    = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] AN_OFF     = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                                 : {DIGITS{1'b0}};

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   disp;
    logic [4*DIGITS-1:0]   pend;

    logic                  tick;
    logic                  boundary;
    logic [3:0]            nib;
    logic [DIGITS-1:0]     an_hot;
    logic                  blank_cur;
    logic [6:0]            seg_lit;
    logic [6:0]            seg_drive;
    logic [DIGITS-1:0]     an_drive;

    // Active-high glyph table, bit0 = a ... bit6 = g; b and d are lowercase.
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    assign tick     = (presc == PRESC_LAST);
    assign boundary = tick && (idx == IDX_LAST);

    // Select the current nibble and build the one-hot anode pattern with an
    // explicit compare loop. Index values past DIGITS-1 cannot occur.
    always_comb begin
        // NOTE: every variable gets a default first so that no path leaves it unassigned (no latch).
        nib    = 4'h0;
        an_hot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = disp[4*i +: 4];
                an_hot[i] = 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank;
    logic              nz_above;

    // Walk from the top digit down. A digit is blanked only while every
    // nibble at or above it is zero. Digit 0 always shows its glyph.
    always_comb begin
        blank    = '0;
        nz_above = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_above = nz_above | (disp[4*i +: 4] != 4'h0);
            blank[i] = (i != 0) && !nz_above;
        end
    end

    assign blank_cur = |(blank & an_hot);
`else
    assign blank_cur = 1'b0;
`endif

    assign seg_lit   = blank_cur ? 7'h00 : hex_glyph(nib);
    assign seg_drive = (ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
    assign an_drive  = (ACTIVE_LOW != 0) ? ~an_hot  : an_hot;

    // NOTE: sequential state uses non-blocking assignments, so every register reads pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc          <= '0;
            idx            <= '0;
            disp           <= '0;
            pend           <= '0;
            update_pending <= 1'b0;
            frame_done     <= 1'b0;
            seg            <= SEG_OFF;
            an             <= AN_OFF;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end

            frame_done <= boundary;

            // The display register changes only at a frame boundary. A write
            // that lands on the boundary goes straight to the display and wins
            // over any older pending value.
            if (boundary && wr_en) begin
                disp           <= wr_data;
                update_pending <= 1'b0;
            end else if (boundary && update_pending) begin
                disp           <= pend;
                update_pending <= 1'b0;
            end else if (wr_en) begin
                pend           <= wr_data;
                update_pending <= 1'b1;
            end

            // Outputs follow idx and disp with one clock of latency.
            seg <= seg_drive;
            an  <= an_drive;
        end
    end

endmodule
